// File: rtl/vm_input_pkg.sv
// vm_input_pkg
// Shared definitions for the vending-machine input conditioner.
//   - chan_state_t and ST_* : per-channel debounce FSM encoding
//   - DEFAULT_DEBOUNCE_CYCLES : default stable-cycle requirement
//   - cnt_width() : debounce counter width ($clog2, never below 1)
package vm_input_pkg;

  typedef logic [1:0] chan_state_t;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ARM_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_ARM_RELEASE = 2'd3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vm_input_conditioner_channel.sv
// debounce_channel
// One conditioned input: two-flop synchroniser, debounce FSM with
// counter, and registered pulse/held outputs.
// Ports:
//   clk    in  prescaled internal clock
//   reset  in  asynchronous, active-high reset
//   raw    in  raw switch/button, asynchronous to clk
//   pulse  out one-cycle pulse on each debounced press
//   held   out high while debounced-pressed (HELD or ARM_RELEASE)
module debounce_channel
  import vm_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic held
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
    $error("debounce_channel: DEBOUNCE_CYCLES must be in 2..255");
  end

  logic          sync_meta_reg;
  logic          sync_reg;
  chan_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          pulse_reg, pulse_next;
  logic          held_reg, held_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sync_reg) begin
          state_next = ST_ARM_PRESS;
          cnt_next   = '0;
        end
      end
      ST_ARM_PRESS: begin
        if (!sync_reg)               state_next = ST_IDLE;
        else if (cnt_reg == CNT_LAST) state_next = ST_HELD;
        else                          cnt_next   = cnt_reg + CW'(1);
      end
      ST_HELD: begin
        if (!sync_reg) begin
          state_next = ST_ARM_RELEASE;
          cnt_next   = '0;
        end
      end
      ST_ARM_RELEASE: begin
        if (sync_reg)                 state_next = ST_HELD;
        else if (cnt_reg == CNT_LAST) state_next = ST_IDLE;
        else                          cnt_next   = cnt_reg + CW'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state transition; only a press-side entry into HELD makes a pulse.
  always_comb begin
    pulse_next = (state_reg == ST_ARM_PRESS) && (state_next == ST_HELD);
    held_next  = (state_next == ST_HELD) || (state_next == ST_ARM_RELEASE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      pulse_reg     <= 1'b0;
      held_reg      <= 1'b0;
    end else begin
      sync_meta_reg <= raw;
      sync_reg      <= sync_meta_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pulse_reg     <= pulse_next;
      held_reg      <= held_next;
    end
  end

  assign pulse = pulse_reg;
  assign held  = held_reg;

endmodule

// File: rtl/vm_input_conditioner.sv
// vm_input_conditioner
// Conditions the coin (m) and accept (a) inputs of the vending FSM:
// each is synchronised, debounced and turned into one pulse per press.
// Optional macro VM_INPUT_INTERLOCK_EN: a pulse is suppressed while the
// other channel is held; on a same-cycle tie m_pulse wins.
// Ports:
//   clk      in  prescaled internal clock
//   reset    in  asynchronous, active-high reset
//   m_raw    in  raw coin switch
//   a_raw    in  raw accept button
//   m_pulse  out one-cycle pulse per debounced coin press
//   a_pulse  out one-cycle pulse per debounced accept press
//   m_held   out coin input debounced-pressed
//   a_held   out accept input debounced-pressed
module vm_input_conditioner
  import vm_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic m_raw,
  input  logic a_raw,
  output logic m_pulse,
  output logic a_pulse,
  output logic m_held,
  output logic a_held
);

  // Index 0 = coin (m), index 1 = accept (a).
  logic [1:0] raw_vec;
  logic [1:0] pulse_vec;
  logic [1:0] held_vec;

  assign raw_vec = {a_raw, m_raw};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[gi]),
      .pulse (pulse_vec[gi]),
      .held  (held_vec[gi])
    );
  end

`ifdef VM_INPUT_INTERLOCK_EN
  // held rises in the same cycle as pulse, so a held accept that is not
  // itself newly pulsing means accept got there first. m_held already
  // covers the simultaneous case for accept, giving m priority.
  assign m_pulse = pulse_vec[0] & ~(held_vec[1] & ~pulse_vec[1]);
  assign a_pulse = pulse_vec[1] & ~held_vec[0];
`else
  assign m_pulse = pulse_vec[0];
  assign a_pulse = pulse_vec[1];
`endif

  assign m_held = held_vec[0];
  assign a_held = held_vec[1];

endmodule

// File: doc/vm_input_conditioner.md
Name: vm_input_conditioner

Overview:
- Front-end stage that feeds the vending-machine credit FSM's coin (m) and accept (a) inputs.
- Each raw button/coin-switch line is synchronised, debounced, and reduced to a single-cycle pulse per physical press.
- Runs on the same prescaled internal clock as the Moore/Mealy FSMs.
- Its pulses drive the FSM's m/a inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or release; legal range 2..255 (elaboration error outside).

Ports:
- clk  input  1  prescaled internal clock
- reset  input  1  asynchronous, active-high reset
- m_raw  input  1  raw coin switch, asynchronous to clk
- a_raw  input  1  raw accept button, asynchronous to clk
- m_pulse  output  1  one-cycle pulse per debounced coin press
- a_pulse  output  1  one-cycle pulse per debounced accept press
- m_held  output  1  high while coin input is debounced-pressed
- a_held  output  1  high while accept input is debounced-pressed

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - While reset is high: all synchroniser flops = 0, both channel states = IDLE, counters = 0, all four outputs = 0 immediately.
- Synchroniser: two flops per raw input. Call the second flop sync.
- Channel FSM, identical per channel. Counter width is $clog2(DEBOUNCE_CYCLES) (min 1).
  - IDLE: sync=1 → ARM_PRESS, cnt=0.
  - ARM_PRESS:
    - sync=0 → IDLE (glitch rejected).
    - Else if cnt==DEBOUNCE_CYCLES-1 → HELD.
    - Else cnt+1.
  - HELD: sync=0 → ARM_RELEASE, cnt=0.
  - ARM_RELEASE:
    - sync=1 → HELD (bounce ignored, no new pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1 → IDLE.
    - Else cnt+1.
- Pulse:
  - Registered; high exactly during the first cycle after entering HELD from ARM_PRESS.
  - Never high on re-entry to HELD from ARM_RELEASE.
- held output: high in HELD and ARM_RELEASE, registered.
- Latency:
  - Edge 0 is the edge that first samples raw high; raw stays high.
  - pulse rises after edge DEBOUNCE_CYCLES+2 and falls after the next edge.
  - held rises with pulse.
- Glitch rules:
  - Any high excursion of sync shorter than DEBOUNCE_CYCLES+1 cycles produces no pulse.
  - Any release shorter than that keeps held high.
- Channels are independent; both pulses may be high in the same cycle (default build).
- Reset mid-operation:
  - Any in-progress press is discarded.
  - If raw is still high after reset deasserts, it is treated as a fresh press and pulses once after the full latency.
- No counter wrap is possible; the counter saturates by state exit.

Optional Feature:
- Macro: VM_INPUT_INTERLOCK_EN.
- With macro:
  - A channel's pulse is suppressed if the other channel's held is high in the cycle the pulse would assert.
  - If both channels would pulse in the same cycle, m_pulse wins and a_pulse is suppressed.
  - held outputs are unaffected.
- Without macro: channels fully independent as above.

Decomposition:
- Package vm_input_pkg:
  - Channel state encoding constants IDLE=0, ARM_PRESS=1, HELD=2, ARM_RELEASE=3 (2-bit type).
  - Default DEBOUNCE_CYCLES constant.
- Sub-module debounce_channel:
  - Contains synchroniser, counter, FSM, and pulse/held registers for one input.
  - Instantiated twice.
- Top level holds only the interlock logic and output wiring.

Test Plan:
- Reset: assert reset mid-press with m in ARM_PRESS → all outputs 0 immediately. Release reset with m_raw held high → m_pulse once, 6 edges after first sample (DEBOUNCE_CYCLES=4).
- Clean press: m_raw 0→1, held 20 cycles, then 0 → exactly one m_pulse after edge 6. m_held high from edge 6 until 6 edges after release sampled.
- Glitch: a_raw high for 3 cycles then low → no a_pulse, a_held stays 0.
- Release bounce: after a_held=1, drop a_raw for 2 cycles then high again → a_held stays 1, no second a_pulse.
- Simultaneous: m_raw and a_raw rise on the same edge →
  - Default: both pulses high in the same cycle.
  - With VM_INPUT_INTERLOCK_EN: only m_pulse.
- Interlock: with VM_INPUT_INTERLOCK_EN, press and hold m, then press a → a_held=1 but no a_pulse. After m released, a new a press → a_pulse.
